// File: rtl/up_reg_pkg.sv
// Shared constants for the up_* bus register bank: register offsets,
// the unmapped-read pattern and a helper that maps a counter index to its offset.
package up_reg_pkg;

    localparam logic [7:0]  OFS_ID      = 8'h00;
    localparam logic [7:0]  OFS_SCRATCH = 8'h04;
    localparam logic [7:0]  OFS_CTRL    = 8'h08;
    localparam logic [7:0]  OFS_CMD     = 8'h0C;
    localparam logic [7:0]  OFS_STATUS  = 8'h10;
    localparam logic [7:0]  OFS_STICKY  = 8'h14;
    localparam logic [7:0]  OFS_CNT0    = 8'h18;

    localparam logic [31:0] RD_UNMAPPED = 32'h0BAD_0BAD;

    // Byte offset of event counter k (counters are packed one word apart).
    function automatic logic [7:0] cnt_ofs(input int unsigned k);
        return OFS_CNT0 + 8'(k * 32'd4);
    endfunction

endpackage

// File: rtl/up_evt_cnt.sv
// One saturating event counter with synchronous load, increment and an
// optional clear-on-read that reloads the same-cycle increment so no event is lost.
module up_evt_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             inc_i,
    input  logic             rd_clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a load beats a clear-on-read, which beats a saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (rd_clr_i) begin
            cnt_d = {{(CNT_W-1){1'b0}}, inc_i};
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/up_reg_bank.sv
// Register-bank slave on the up_* CPU bus: ID, SCRATCH, CTRL, CMD pulses,
// STATUS, STICKY events and NUM_CNT saturating event counters.
// Read data is registered and reflects the pre-update register value.
// Optional feature: define UP_REG_COR_EN to make counters clear-on-read.
module up_reg_bank
    import up_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = 32'h5345_0001,
    parameter int          NUM_CNT   = 4,
    parameter int          CNT_W     = 32
) (
    input  logic               up_clk,
    input  logic               up_rst,
    input  logic               up_cs,
    input  logic               up_wr,
    input  logic               up_rd,
    input  logic [31:0]        up_addr,
    input  logic [31:0]        up_data_wr,
    output logic [31:0]        up_data_rd,
    output logic [31:0]        ctrl_out,
    output logic [31:0]        cmd_pulse,
    input  logic [31:0]        status_in,
    input  logic [31:0]        sticky_in,
    input  logic [NUM_CNT-1:0] cnt_inc
);

    logic             sel_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic [7:0]       ofs_s;
    logic             unused_addr_s;
    logic [31:0]      rd_mux_s;
    logic [NUM_CNT-1:0] cnt_hit_s;
    logic [NUM_CNT-1:0] cnt_rd_clr_s;
    logic [CNT_W-1:0] cnt_val_s [NUM_CNT];

    logic [31:0] up_data_rd_q, up_data_rd_d;
    logic [31:0] scratch_q,    scratch_d;
    logic [31:0] ctrl_q,       ctrl_d;
    logic [31:0] cmd_pulse_q,  cmd_pulse_d;
    logic [31:0] sticky_q,     sticky_d;

    // A write strobe takes precedence: a cycle with both strobes is a write only.
    assign sel_s         = up_cs && (up_addr[31:8] == BASE_ADDR[31:8]);
    assign wr_en_s       = sel_s && up_wr;
    assign rd_en_s       = sel_s && up_rd && !up_wr;
    assign ofs_s         = {up_addr[7:2], 2'b00};
    assign unused_addr_s = ^up_addr[1:0];

    genvar k;
    generate
        for (k = 0; k < NUM_CNT; k++) begin : g_cnt
            assign cnt_hit_s[k] = (ofs_s == cnt_ofs(k));
`ifdef UP_REG_COR_EN
            assign cnt_rd_clr_s[k] = rd_en_s && cnt_hit_s[k];
`else
            assign cnt_rd_clr_s[k] = 1'b0;
`endif
            up_evt_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk_i      (up_clk),
                .rst_i      (up_rst),
                .load_i     (wr_en_s && cnt_hit_s[k]),
                .load_val_i (up_data_wr[CNT_W-1:0]),
                .inc_i      (cnt_inc[k]),
                .rd_clr_i   (cnt_rd_clr_s[k]),
                .cnt_o      (cnt_val_s[k])
            );
        end
    endgenerate

    // Read multiplexer over the current (pre-update) register values.
    always_comb begin
        rd_mux_s = RD_UNMAPPED;
        case (ofs_s)
            OFS_ID:      rd_mux_s = ID_VALUE;
            OFS_SCRATCH: rd_mux_s = scratch_q;
            OFS_CTRL:    rd_mux_s = ctrl_q;
            OFS_CMD:     rd_mux_s = 32'h0000_0000;
            OFS_STATUS:  rd_mux_s = status_in;
            OFS_STICKY:  rd_mux_s = sticky_q;
            default: begin
                rd_mux_s = RD_UNMAPPED;
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (cnt_hit_s[i]) begin
                        rd_mux_s                = 32'h0000_0000;
                        rd_mux_s[CNT_W-1:0]     = cnt_val_s[i];
                    end else begin
                        rd_mux_s = rd_mux_s;
                    end
                end
            end
        endcase
    end

    // Next-state for the bus-visible registers; sticky sets win over write-1-clear.
    always_comb begin
        up_data_rd_d = rd_en_s ? rd_mux_s : up_data_rd_q;
        scratch_d    = (wr_en_s && (ofs_s == OFS_SCRATCH)) ? up_data_wr : scratch_q;
        ctrl_d       = (wr_en_s && (ofs_s == OFS_CTRL))    ? up_data_wr : ctrl_q;
        cmd_pulse_d  = (wr_en_s && (ofs_s == OFS_CMD))     ? up_data_wr : 32'h0000_0000;
        if (wr_en_s && (ofs_s == OFS_STICKY)) begin
            sticky_d = (sticky_q & ~up_data_wr) | sticky_in;
        end else begin
            sticky_d = sticky_q | sticky_in;
        end
    end

    // Register update; reset discards any access strobed in the same cycle.
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            up_data_rd_q <= 32'h0000_0000;
            scratch_q    <= 32'h0000_0000;
            ctrl_q       <= 32'h0000_0000;
            cmd_pulse_q  <= 32'h0000_0000;
            sticky_q     <= 32'h0000_0000;
        end else begin
            up_data_rd_q <= up_data_rd_d;
            scratch_q    <= scratch_d;
            ctrl_q       <= ctrl_d;
            cmd_pulse_q  <= cmd_pulse_d;
            sticky_q     <= sticky_d;
        end
    end

    assign up_data_rd = up_data_rd_q;
    assign ctrl_out   = ctrl_q;
    assign cmd_pulse  = cmd_pulse_q;

endmodule

// File: tb/tb_up_reg_bank.sv
// Self-checking bench for up_reg_bank: directed test-plan sequences with literal
// expectations, then randomized bus/event traffic checked every cycle against a
// behavioural model of the register map.
module tb_up_reg_bank;

    localparam int NUM_CNT = 4;
    localparam int CNT_W   = 32;
`ifdef UP_REG_COR_EN
    localparam bit COR = 1'b1;
`else
    localparam bit COR = 1'b0;
`endif
    localparam longint CMAX = (64'd1 << CNT_W) - 64'd1;

    logic               up_clk = 1'b0;
    logic               up_rst = 1'b1;
    logic               up_cs = 1'b0, up_wr = 1'b0, up_rd = 1'b0;
    logic [31:0]        up_addr = 32'h0, up_data_wr = 32'h0;
    logic [31:0]        up_data_rd, ctrl_out, cmd_pulse;
    logic [31:0]        status_in = 32'h0, sticky_in = 32'h0;
    logic [NUM_CNT-1:0] cnt_inc = '0;

    up_reg_bank #(
        .BASE_ADDR (32'h0000_0000),
        .ID_VALUE  (32'h5345_0001),
        .NUM_CNT   (NUM_CNT),
        .CNT_W     (CNT_W)
    ) dut (
        .up_clk     (up_clk),
        .up_rst     (up_rst),
        .up_cs      (up_cs),
        .up_wr      (up_wr),
        .up_rd      (up_rd),
        .up_addr    (up_addr),
        .up_data_wr (up_data_wr),
        .up_data_rd (up_data_rd),
        .ctrl_out   (ctrl_out),
        .cmd_pulse  (cmd_pulse),
        .status_in  (status_in),
        .sticky_in  (sticky_in),
        .cnt_inc    (cnt_inc)
    );

    always #5 up_clk = ~up_clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Behavioural state of the register map.
    logic [31:0] m_scratch, m_ctrl, m_sticky;
    longint      m_cnt [NUM_CNT];
    logic [31:0] exp_rd, exp_ctrl, exp_cmd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] o);
        int idx;
        case (o)
            8'h00: return 32'h5345_0001;
            8'h04: return m_scratch;
            8'h08: return m_ctrl;
            8'h0C: return 32'h0;
            8'h10: return status_in;
            8'h14: return m_sticky;
            default: begin
                idx = (int'(o) - 24) / 4;
                if (o >= 8'h18 && idx < NUM_CNT) return m_cnt[idx][31:0];
                return 32'h0BAD_0BAD;
            end
        endcase
    endfunction

    // Apply the bus inputs present at this clock edge to the model.
    task automatic model_edge();
        bit sel, w, r;
        logic [7:0] o;
        logic [31:0] clr;
        sel = up_cs && (up_addr[31:8] == 24'h0);
        w   = sel && up_wr;
        r   = sel && up_rd && !up_wr;
        o   = {up_addr[7:2], 2'b00};
        if (up_rst) begin
            m_scratch = 32'h0; m_ctrl = 32'h0; m_sticky = 32'h0;
            for (int k = 0; k < NUM_CNT; k++) m_cnt[k] = 0;
            exp_rd = 32'h0; exp_cmd = 32'h0;
        end else begin
            if (r) exp_rd = model_read(o);
            exp_cmd = (w && o == 8'h0C) ? up_data_wr : 32'h0;
            if (w && o == 8'h04) m_scratch = up_data_wr;
            if (w && o == 8'h08) m_ctrl = up_data_wr;
            clr = (w && o == 8'h14) ? up_data_wr : 32'h0;
            m_sticky = (m_sticky & ~clr) | sticky_in;
            for (int k = 0; k < NUM_CNT; k++) begin
                if (w && int'(o) == 24 + 4 * k) m_cnt[k] = longint'(up_data_wr) & CMAX;
                else if (COR && r && int'(o) == 24 + 4 * k) m_cnt[k] = cnt_inc[k] ? 1 : 0;
                else if (cnt_inc[k] && m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
            end
        end
        exp_ctrl = m_ctrl;
    endtask

    task automatic step();
        @(posedge up_clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic idle();
        up_cs = 1'b0; up_wr = 1'b0; up_rd = 1'b0;
    endtask

    task automatic wr_bus(input logic [31:0] a, input logic [31:0] d);
        up_cs = 1'b1; up_wr = 1'b1; up_rd = 1'b0; up_addr = a; up_data_wr = d;
        step();
        idle();
    endtask

    task automatic rd_bus(input logic [31:0] a, output logic [31:0] d);
        up_cs = 1'b1; up_wr = 1'b0; up_rd = 1'b1; up_addr = a;
        step();
        idle();
        d = up_data_rd;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge up_clk) begin
        if (chk_en) begin
            chk("model_rd",   up_data_rd, exp_rd);
            chk("model_ctrl", ctrl_out,   exp_ctrl);
            chk("model_cmd",  cmd_pulse,  exp_cmd);
        end
    end

    logic [31:0] d;
    logic [7:0]  ofs_tab [12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                                  8'h18, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h40};

    initial begin
        int start, rise, lat;
        bit found;
        step(); step();
        up_rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_rd",   up_data_rd, 32'h0);
        chk("reset_ctrl", ctrl_out,   32'h0);
        chk("reset_cmd",  cmd_pulse,  32'h0);

        rd_bus(32'h00, d);           chk("id", d, 32'h5345_0001);
        wr_bus(32'h04, 32'hA5A5_5A5A);
        rd_bus(32'h04, d);           chk("scratch", d, 32'hA5A5_5A5A);
        rd_bus(32'h40, d);           chk("unmapped", d, 32'h0BAD_0BAD);
        wr_bus(32'h08, 32'h0000_CAFE);
        chk("ctrl_wr", ctrl_out, 32'h0000_CAFE);

        wr_bus(32'h0C, 32'h0000_0011);
        chk("cmd_pulse_on", cmd_pulse, 32'h0000_0011);
        step();
        chk("cmd_pulse_off", cmd_pulse, 32'h0);
        rd_bus(32'h0C, d);           chk("cmd_read", d, 32'h0);

        sticky_in = 32'h8; step(); sticky_in = 32'h0;
        rd_bus(32'h14, d);           chk("sticky_set", d, 32'h8);
        sticky_in = 32'h8; wr_bus(32'h14, 32'h8); sticky_in = 32'h0;
        rd_bus(32'h14, d);           chk("sticky_set_wins", d, 32'h8);
        wr_bus(32'h14, 32'h8);
        rd_bus(32'h14, d);           chk("sticky_clr", d, 32'h0);

        cnt_inc = 4'b0001;
        repeat (10) step();
        cnt_inc = 4'b0000;
        rd_bus(32'h18, d);           chk("cnt_10", d, 32'd10);
        rd_bus(32'h18, d);           chk("cnt_reread", d, COR ? 32'd0 : 32'd10);
        wr_bus(32'h18, 32'hFFFF_FFFE);
        cnt_inc = 4'b0001;
        repeat (5) step();
        cnt_inc = 4'b0000;
        rd_bus(32'h18, d);           chk("cnt_sat", d, 32'hFFFF_FFFF);

        start = cyc; rise = -1; found = 1'b0; lat = 0;
        for (int p = 0; p < 40 && !found; p++) begin
            for (int s = 0; s < 4; s++) begin
                if (cyc - start == 20) begin status_in = 32'h1; rise = cyc; end
                if (s == 0) begin
                    up_cs = 1'b1; up_rd = 1'b1; up_addr = 32'h10;
                    step(); idle();
                    if (rise >= 0 && up_data_rd[0] && !found) begin
                        found = 1'b1; lat = cyc - rise;
                    end
                end else begin
                    step();
                end
            end
        end
        chk("poll_seen", {31'h0, found}, 32'h1);
        chk("poll_latency_le4", {31'h0, (lat <= 4)}, 32'h1);
        status_in = 32'h0;

        up_cs = 1'b1; up_wr = 1'b1; up_addr = 32'h08; up_data_wr = 32'h1234; up_rst = 1'b1;
        step();
        up_rst = 1'b0; idle();
        step();
        chk("rst_discards_wr", ctrl_out, 32'h0);

        for (int i = 0; i < 600; i++) begin
            logic [7:0] o;
            o = ofs_tab[$urandom_range(0, 11)];
            up_cs   = ($urandom_range(0, 3) != 0);
            up_wr   = ($urandom_range(0, 2) == 0);
            up_rd   = ($urandom_range(0, 1) == 0);
            up_addr = {($urandom_range(0, 9) == 0) ? 24'h000001 : 24'h0, o[7:2],
                       2'($urandom_range(0, 3))};
            up_data_wr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
            status_in = $urandom;
            sticky_in = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            cnt_inc   = 4'($urandom);
            up_rst    = ($urandom_range(0, 99) == 0);
            step();
        end
        up_rst = 1'b0; idle();
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/up_reg_bank.md
# up_reg_bank

Register-bank responder on the tester's `up_*` CPU bus. It is the slave end of the bus the CPU bus-functional model drives. It decodes single-cycle read and write strobes and returns registered read data. It holds the tester's control, command, status, sticky-event and event-counter registers. It sits between the CPU bus and the generator/checker datapath, so directed scripts (`rd`/`wr`/`pl`) can configure and poll the design.

## Interface
- `BASE_ADDR`, 32'h0000_0000: block base; `up_addr[31:8]` must equal `BASE_ADDR[31:8]` to select.
- `ID_VALUE`, 32'h5345_0001: constant returned at offset 0x00.
- `NUM_CNT`, 4: number of event counters, range 1..8.
- `CNT_W`, 32: counter width, range 8..32; read zero-extended.

Ports:
- `up_clk` in 1: sole clock.
- `up_rst` in 1: synchronous, active-high reset.
- `up_cs` in 1: chip select, one-cycle strobe.
- `up_wr` in 1: write strobe, qualified by `up_cs`.
- `up_rd` in 1: read strobe, qualified by `up_cs`.
- `up_addr` in 32: byte address, word aligned; bits [1:0] ignored.
- `up_data_wr` in 32: write data.
- `up_data_rd` out 32: registered read data, held until the next selected read.
- `ctrl_out` out 32: CTRL register contents.
- `cmd_pulse` out 32: one-cycle pulses from CMD writes.
- `status_in` in 32: live status, already synchronous to `up_clk`.
- `sticky_in` in 32: event-set inputs for STICKY.
- `cnt_inc` in NUM_CNT: per-counter increment enables.

## Operation
- sel = `up_cs` & address match. wr_en = sel & `up_wr`. rd_en = sel & `up_rd` & !`up_wr`. If both strobes are asserted, the access is a write only.
- Offset map (`up_addr[7:0]`):
  - 0x00 ID: RO.
  - 0x04 SCRATCH: RW, reset 0.
  - 0x08 CTRL: RW, reset 0.
  - 0x0C CMD: write-1-pulse; reads 0.
  - 0x10 STATUS: RO, samples `status_in`.
  - 0x14 STICKY: bit set while `sticky_in[i]`=1; write-1 clears the bit.
  - 0x18 + 4k: counter k, for k < NUM_CNT.
- Unmapped offsets:
  - A read returns 32'h0BAD_0BAD.
  - A write is ignored.
- STICKY: if a set and a write-1-clear hit the same bit in the same cycle, the set wins.
- Counters:
  - Increment by 1 per cycle while `cnt_inc[k]`=1.
  - Saturate at 2^CNT_W−1; no wrap.
  - A write to a counter offset loads `up_data_wr[CNT_W-1:0]`.
- Read data is the pre-update value of the register in the same cycle. Example: STICKY read while also being cleared returns the old bits.
- Deselected cycles leave `up_data_rd` and all registers unchanged, apart from input-driven updates.

## Timing
- Write: the register updates at the clock edge that samples wr_en. The new value is visible on `ctrl_out` one cycle later.
- `cmd_pulse[i]` is high for exactly the one cycle after the CMD write edge, for each data bit that was 1. It is 0 otherwise.
- Read: `up_data_rd` is valid one cycle after the edge that sampled rd_en. This is well inside the master's 2-cycle sample window.
- Polling reads are back-to-back with 3 idle cycles between them. No read state is lost across idle cycles.
- Reset, effective at the next edge even mid-access:
  - Outputs: `up_data_rd`=0, `ctrl_out`=0, `cmd_pulse`=0.
  - Registers: SCRATCH, STICKY and all counters = 0.
  - An access strobed in the same cycle as reset is discarded.
- No FSM beyond the registered decode. Latency is fixed: write 1 cycle, read 1 cycle.

## Configuration
- `UP_REG_COR_EN` defined: counters are clear-on-read.
  - A counter read returns the current value.
  - The counter then loads `cnt_inc[k]` (0 or 1) the same edge, so no simultaneous increment is lost.
- Undefined: reads are non-destructive. Counters clear only by write or reset.

## Structure
- Package `up_reg_pkg` holds:
  - offset constants: `OFS_ID`, `OFS_SCRATCH`, `OFS_CTRL`, `OFS_CMD`, `OFS_STATUS`, `OFS_STICKY`, `OFS_CNT0`;
  - `RD_UNMAPPED` = 32'h0BAD_0BAD.
- Sub-module `up_evt_cnt`: one saturating counter with load, increment and clear-on-read. It is instantiated NUM_CNT times via generate.

## Test plan
- Reset, then read 0x00 → 32'h5345_0001. Then write 0x04=32'hA5A5_5A5A and read back → A5A5_5A5A. Read 0x40 → 32'h0BAD_0BAD.
- Write 0x0C=32'h0000_0011 → `cmd_pulse`=0x11 for exactly one cycle, then 0. Read 0x0C → 0.
- Pulse `sticky_in[3]` for 1 cycle. Read 0x14 → 0x8. Write 0x14=0x8 while holding `sticky_in[3]`=1 → bit stays set. Release, clear again → read 0.
- Hold `cnt_inc[0]` high for 10 cycles, then read 0x18 → 10.
  - With `UP_REG_COR_EN`, a second read → 0.
  - Without it → 10.
  - Load 0xFFFF_FFFE and increment for 5 cycles → 0xFFFF_FFFF.
- Poll: `status_in[0]` rises 20 cycles after polling of 0x10 starts → a read returns bit0=1 within 4 cycles of the rise.
- Assert `up_rst` during a write strobe to 0x08=0x1234 → `ctrl_out` stays 0 after reset.
